// File: rtl/stream_mux_rr_pkg.sv
// rtl/stream_mux_rr_pkg.sv - shared mode encodings for the round-robin stream mux
package stream_mux_rr_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - combinational round-robin arbiter starting its scan at ptr
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any_gnt
);

  logic [SELW:0] cand;

  // ptr is always < NCH, so one conditional subtract wraps the scan index
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = {1'b0, ptr} + (SELW+1)'(i);
      if (cand >= (SELW+1)'(NCH)) begin
        cand = cand - (SELW+1)'(NCH);
      end
      if (!any_gnt && req[cand[SELW-1:0]]) begin
        any_gnt                = 1'b1;
        gnt_idx                = cand[SELW-1:0];
        gnt[cand[SELW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel stream mux with manual or round-robin select and registered output
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic            load_en;
  logic [SELW-1:0] ptr;
  logic [NCH-1:0]  rr_gnt;
  logic [SELW-1:0] rr_idx;
  logic            rr_any;
  logic [NCH-1:0]  man_gnt;
  logic            man_any;
  logic [NCH-1:0]  grant;
  logic [SELW-1:0] gidx;
  logic            any_gnt;
  logic [SELW-1:0] ptr_next;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any_gnt (rr_any)
  );

  // out-of-range sel in a non-power-of-two build simply yields no grant
  always_comb begin
    man_gnt = '0;
    man_any = 1'b0;
    if (({1'b0, sel} < (SELW+1)'(NCH)) && in_valid[sel]) begin
      man_gnt[sel] = 1'b1;
      man_any      = 1'b1;
    end
  end

  always_comb begin
    grant   = man_gnt;
    gidx    = sel;
    any_gnt = man_any;
    if (mode == MODE_RR) begin
      grant   = rr_gnt;
      gidx    = rr_idx;
      any_gnt = rr_any;
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign in_ready = (rst_n && load_en) ? grant : '0;
  assign ptr_next = ({1'b0, gidx} == (SELW+1)'(NCH-1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= any_gnt;
      if (any_gnt) begin
        out_data <= in_data[gidx*WIDTH +: WIDTH];
        out_ch   <= gidx;
        if (mode == MODE_RR) begin
          ptr <= ptr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed self-checking bench for stream_mux_rr
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic [2:0]  sel5;
  logic [19:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [3:0]  out_data5;
  logic [2:0]  out_ch5;
  logic        out_valid5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(4), .NCH(4), .SELW(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  stream_mux_rr #(.WIDTH(4), .NCH(5), .SELW(3)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (1'b0),
    .sel       (sel5),
    .in_data   (in_data5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .out_data  (out_data5),
    .out_ch    (out_ch5),
    .out_valid (out_valid5),
    .out_ready (1'b1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_rr2[4];
    exp_rr2 = '{1, 3, 1, 3};

    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_data   = {4'h4, 4'h3, 4'h2, 4'h1};
    in_valid  = 4'hF;
    out_ready = 1'b1;
    sel5      = 3'd0;
    in_data5  = {4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
    in_valid5 = 5'h1F;
    #1;
    chk("rst_ready0", in_ready, 4'b0000);

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 4'h0);
      chk("rst_ch", out_ch, 2'd0);
      chk("rst_ready", in_ready, 4'b0000);
    end

    rst_n = 1'b1;
    #1;
    chk("first_ready", in_ready, 4'b0001);

    // all valid: full-rate rotation 0..3 twice
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_all_ch", out_ch, 32'(i % 4));
      chk("rr_all_data", out_data, 32'(i % 4 + 1));
      chk("rr_all_valid", out_valid, 1'b1);
    end

    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_13_ch", out_ch, 32'(exp_rr2[i]));
    end

    // move ptr to 3 via ch2, then only ch0 valid
    in_valid = 4'b0100;
    tick();
    chk("wrap_ch2", out_ch, 2'd2);
    in_valid = 4'b0001;
    #1;
    chk("wrap_ready", in_ready, 4'b0001);
    tick();
    chk("wrap_ch0", out_ch, 2'd0);
    in_valid = 4'hF;
    #1;
    chk("ptr1_ready", in_ready, 4'b0010);
    tick();
    chk("ptr1_ch", out_ch, 2'd1);

    mode     = 1'b0;
    sel      = 2'd2;
    in_data[8 +: 4] = 4'hA;
    in_valid = 4'b0100;
    #1;
    chk("man_ready", in_ready, 4'b0100);
    tick();
    chk("man_data", out_data, 4'hA);
    chk("man_ch", out_ch, 2'd2);

    sel = 2'd3;
    #1;
    chk("man_nogrant", in_ready, 4'b0000);
    tick();
    chk("man_drop_valid", out_valid, 1'b0);
    chk("man_hold_data", out_data, 4'hA);

    sel      = 2'd1;
    in_valid = 4'b0010;
    in_data[4 +: 4] = 4'h5;
    tick();
    chk("bp_load", out_data, 4'h5);
    chk("bp_load_ch", out_ch, 2'd1);
    out_ready = 1'b0;
    in_data[4 +: 4] = 4'h6;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", in_ready, 4'b0000);
      tick();
      chk("bp_hold", out_data, 4'h5);
      chk("bp_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 4'b0010);
    tick();
    chk("bp_new", out_data, 4'h6);

    mode     = 1'b1;
    in_valid = 4'b0010;
    tick();
    chk("mid_ch1", out_ch, 2'd1);
    out_ready = 1'b0;
    tick();
    chk("mid_held", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 4'b0000);
    tick();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ch", out_ch, 2'd0);
    chk("mid_rst_data", out_data, 4'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    #1;
    chk("post_rst_ready", in_ready, 4'b0001);
    tick();
    chk("post_rst_ch", out_ch, 2'd0);

    sel5 = 3'd4;
    #1;
    chk("n5_ready4", in_ready5, 5'b10000);
    tick();
    chk("n5_data", out_data5, 4'h7);
    chk("n5_ch", out_ch5, 3'd4);
    chk("n5_valid", out_valid5, 1'b1);
    sel5 = 3'd5;
    #1;
    chk("n5_oor_ready", in_ready5, 5'b00000);
    tick();
    chk("n5_oor_valid", out_valid5, 1'b0);
    chk("n5_oor_ch", out_ch5, 3'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
